// File: rtl/z80_pkg.sv
// Shared Z80 bus fabric types: master/slave bus structs, wait-state FSM
// encoding and the bus-strobe helper used by memory slaves.
package z80_pkg;

    localparam int Z80_ADDR_W = 16;
    localparam int Z80_DATA_W = 8;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } z80ws_state_t;

    typedef struct packed {
        logic [Z80_ADDR_W-1:0] addr;
        logic [Z80_DATA_W-1:0] dmaster;
        logic                  mreqn;
        logic                  rdn;
        logic                  wrn;
    } Z80MasterBus;

    typedef struct packed {
        logic [Z80_DATA_W-1:0] dslave;
        logic                  mwait;
    } Z80SlaveBus;

    // A memory request is live while MREQ and at least one of RD/WR are low.
    function automatic logic bus_strobe(input Z80MasterBus b);
        return (!b.mreqn) && ((!b.rdn) || (!b.wrn));
    endfunction

endpackage

// File: rtl/z80ram_ws_ram.sv
// Single-port storage array with registered read data; read data holds
// its value until the next read strobe.
module z80ram_ws_ram
    import z80_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rd,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [2**ADDR_W];
    logic [DATA_W-1:0] rdata_r;

    // write port: array contents are not reset
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_r[addr] <= wdata;
        end
    end

    // registered read port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_r <= '0;
        end else if (rd) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/z80ram_ws.sv
// Z80 memory slave window: region decode, wait-state FSM, write protection
// and one storage strobe per bus transaction.
module z80ram_ws
    import z80_pkg::*;
#(
    parameter int          ADDR_W      = 14,
    parameter int          DATA_W      = 8,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          WAIT_STATES = 1,
    parameter int          READ_ONLY   = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ena,
    input  Z80MasterBus ibus,
    output Z80SlaveBus  obus,
    input  logic        wp,
    output logic        sel,
    output logic        wp_viol
);

    // A full-width window (ADDR_W=16) shifts the mask to zero: every request hits.
    localparam logic [Z80_ADDR_W-1:0] TAG_MASK = {Z80_ADDR_W{1'b1}} << ADDR_W;
    localparam logic                  HAS_WAIT = (WAIT_STATES > 0);
    localparam logic                  ROM_MODE = (READ_ONLY != 0);
    localparam logic [WAIT_CNT_W-1:0] CNT_ZERO = WAIT_CNT_W'(0);
    localparam logic [WAIT_CNT_W-1:0] CNT_ONE  = WAIT_CNT_W'(1);
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : CNT_ZERO;

    z80ws_state_t          state_r;
    z80ws_state_t          state_nxt_s;
    logic [WAIT_CNT_W-1:0] cnt_r;
    logic [WAIT_CNT_W-1:0] cnt_nxt_s;
    logic                  strobe_s;
    logic                  hit_s;
    logic                  wr_req_s;
    logic                  access_s;
    logic                  issue_s;
    logic                  rd_s;
    logic                  wr_s;
    logic                  viol_s;
    logic                  wp_viol_r;
    logic                  mwait_s;
    logic [DATA_W-1:0]     rdata_s;

    assign strobe_s = bus_strobe(ibus);
    assign hit_s    = strobe_s && (((ibus.addr ^ BASE_ADDR) & TAG_MASK) == {Z80_ADDR_W{1'b0}});
    assign sel      = hit_s;
    // Both strobes low counts as a write.
    assign wr_req_s = !ibus.wrn;
    assign issue_s  = access_s && ena;
    assign rd_s     = issue_s && !wr_req_s;
    assign wr_s     = issue_s && wr_req_s && !ROM_MODE && !wp;
    assign viol_s   = issue_s && wr_req_s && (ROM_MODE || wp);
    assign wp_viol  = wp_viol_r;

    // next-state, counter and access-issue decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        access_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (hit_s && HAS_WAIT) begin
                    cnt_nxt_s   = CNT_LOAD;
                    state_nxt_s = WAIT;
                end else if (hit_s) begin
                    access_s    = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (!hit_s) begin
                    state_nxt_s = IDLE;
                end else if (cnt_r != CNT_ZERO) begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end else begin
                    access_s    = 1'b1;
                    state_nxt_s = DONE;
                end
            end
            // DONE holds until the master drops the strobes, so a long
            // strobe never produces a second access.
            DONE: begin
                if (!strobe_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = DONE;
            end
        endcase
    end

    // WAIT is combinational so it is visible in the cycle MREQ is asserted
    always_comb begin
        mwait_s = 1'b1;
        if ((state_r == IDLE && hit_s && HAS_WAIT) || (state_r == WAIT && cnt_r != CNT_ZERO)) begin
            mwait_s = 1'b0;
        end else begin
            mwait_s = 1'b1;
        end
        obus                    = '0;
        obus.dslave[DATA_W-1:0] = rdata_s;
        obus.mwait              = mwait_s;
    end

    // FSM, counter and violation pulse advance only on enabled cycles
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= DONE;
            cnt_r     <= CNT_ZERO;
            wp_viol_r <= 1'b0;
        end else if (ena) begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            wp_viol_r <= viol_s;
        end
    end

    z80ram_ws_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .rd    (rd_s),
        .wr    (wr_s),
        .addr  (ibus.addr[ADDR_W-1:0]),
        .wdata (ibus.dmaster[DATA_W-1:0]),
        .rdata (rdata_s)
    );

endmodule

// File: tb/tb_z80ram_ws.sv
// Scoreboard bench: three regions (RAM ws=2, RAM ws=0, ROM ws=3) share one
// master bus; a region/memory model predicts waits, violations and read data.
module tb_z80ram_ws;
    import z80_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ena;
    logic        wp;
    Z80MasterBus ibus;
    Z80SlaveBus  obus_s [3];
    logic        sel_s  [3];
    logic        viol_s [3];

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;
    int n_seen = 0;
    bit ena_mode = 1'b0;
    bit mon_on   = 1'b0;

    typedef struct {
        int         t;
        bit         wr;
        bit         wpv;
        logic [7:0] ds [3];
        bit         kn [3];
    } exp_t;

    exp_t       exp_q [$];
    exp_t       mon_e;
    logic [7:0] mem_m [int];
    logic [7:0] last_m  [3];
    bit         known_m [3];
    int         waits_c [3];
    int         viol_c  [3];
    int         sel_bad = 0;
    logic [13:0] pool [8] = '{14'h0123, 14'h0010, 14'h0200, 14'h0000,
                              14'h0001, 14'h3FFF, 14'h1555, 14'h2AAA};

    always #5 clk = ~clk;

    z80ram_ws #(.ADDR_W(14), .DATA_W(8), .BASE_ADDR(16'h8000), .WAIT_STATES(2), .READ_ONLY(0)) u0 (
        .clk(clk), .rstn(rstn), .ena(ena), .ibus(ibus), .obus(obus_s[0]),
        .wp(wp), .sel(sel_s[0]), .wp_viol(viol_s[0]));
    z80ram_ws #(.ADDR_W(14), .DATA_W(8), .BASE_ADDR(16'h4000), .WAIT_STATES(0), .READ_ONLY(0)) u1 (
        .clk(clk), .rstn(rstn), .ena(ena), .ibus(ibus), .obus(obus_s[1]),
        .wp(wp), .sel(sel_s[1]), .wp_viol(viol_s[1]));
    z80ram_ws #(.ADDR_W(14), .DATA_W(8), .BASE_ADDR(16'hC000), .WAIT_STATES(3), .READ_ONLY(1)) u2 (
        .clk(clk), .rstn(rstn), .ena(ena), .ibus(ibus), .obus(obus_s[2]),
        .wp(wp), .sel(sel_s[2]), .wp_viol(viol_s[2]));

    // Memory map of the bench: 8000-BFFF u0, 4000-7FFF u1, C000-FFFF u2, 0000-3FFF unmapped.
    function automatic int region_of(input logic [15:0] a);
        case (a[15:14])
            2'b10:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return -1;
        endcase
    endfunction

    function automatic int ws_of(input int i);
        case (i)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic bit ro_of(input int i);
        return i == 2;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ena_cycles(input int n);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 1000) begin
            @(posedge clk);
            if (ena) k++;
            #1;
            ena = ena_mode ? ($urandom_range(3) != 0) : 1'b1;
            guard++;
        end
        if (k < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL ena_budget: got %0d enabled cycles expected %0d", k, n);
        end
    endtask

    task automatic txn(input logic [15:0] a, input bit wr, input logic [7:0] d, input bit wpv, input int extra);
        exp_t e;
        int   t;
        int   key;
        t   = region_of(a);
        key = t * 65536 + int'(a[13:0]);
        if (t >= 0) begin
            if (wr) begin
                if (!ro_of(t) && !wpv) mem_m[key] = d;
            end else if (mem_m.exists(key)) begin
                last_m[t]  = mem_m[key];
                known_m[t] = 1'b1;
            end else begin
                known_m[t] = 1'b0;
            end
        end
        e.t   = t;
        e.wr  = wr;
        e.wpv = wpv;
        for (int i = 0; i < 3; i++) begin
            e.ds[i] = last_m[i];
            e.kn[i] = known_m[i];
        end
        exp_q.push_back(e);
        wp           = wpv;
        ibus.addr    = a;
        ibus.dmaster = d;
        ibus.mreqn   = 1'b0;
        ibus.wrn     = !wr;
        ibus.rdn     = wr ? ($urandom_range(1) == 1) : 1'b0;
        ena_cycles(((t >= 0) ? ws_of(t) : 0) + 1 + extra);
        ibus.mreqn = 1'b1;
        ibus.rdn   = 1'b1;
        ibus.wrn   = 1'b1;
        ena_cycles(1);
        wp = 1'b0;
        n_done++;
    endtask

    // monitor: score the finished transaction, then accumulate the current cycle
    always @(negedge clk) begin
        if (n_seen != n_done) begin
            n_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_underflow: got 0 entries expected 1");
            end else begin
                mon_e = exp_q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("waits[%0d]", i), waits_c[i], (i == mon_e.t) ? ws_of(i) : 0);
                    check($sformatf("wp_viol[%0d]", i), viol_c[i],
                          (i == mon_e.t && mon_e.wr && (ro_of(i) || mon_e.wpv)) ? 1 : 0);
                    if (mon_e.kn[i]) check($sformatf("dslave[%0d]", i), obus_s[i].dslave, mon_e.ds[i]);
                end
                check("sel_decode", sel_bad, 0);
            end
            for (int i = 0; i < 3; i++) begin
                waits_c[i] = 0;
                viol_c[i]  = 0;
            end
            sel_bad = 0;
        end
        if (mon_on) begin
            for (int i = 0; i < 3; i++) begin
                if (ena && !obus_s[i].mwait) waits_c[i]++;
                if (ena && viol_s[i]) viol_c[i]++;
                if (sel_s[i] !== (!ibus.mreqn && (!ibus.rdn || !ibus.wrn) && region_of(ibus.addr) == i)) sel_bad++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int lows;
        rstn = 1'b0; ena = 1'b1; wp = 1'b0;
        ibus.addr = 16'h0000; ibus.dmaster = 8'h00;
        ibus.mreqn = 1'b1; ibus.rdn = 1'b1; ibus.wrn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            last_m[i] = 8'h00; known_m[i] = 1'b1; waits_c[i] = 0; viol_c[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_mwait[%0d]", i), obus_s[i].mwait, 1);
            check($sformatf("reset_dslave[%0d]", i), obus_s[i].dslave, 0);
            check($sformatf("reset_wp_viol[%0d]", i), viol_s[i], 0);
            check($sformatf("reset_sel[%0d]", i), sel_s[i], 0);
        end
        #3 rstn = 1'b1;
        ena_cycles(2);
        mon_on = 1'b1;

        // directed: long-held write, read-back, zero-wait reads, miss, protection
        txn(16'h8123, 1'b1, 8'hA5, 1'b0, 2);
        txn(16'h8123, 1'b0, 8'h00, 1'b0, 0);
        txn(16'h4000, 1'b1, 8'h11, 1'b0, 0);
        txn(16'h4001, 1'b1, 8'h22, 1'b0, 0);
        txn(16'h4000, 1'b0, 8'h00, 1'b0, 0);
        txn(16'h4001, 1'b0, 8'h00, 1'b0, 0);
        txn(16'h1000, 1'b0, 8'h00, 1'b0, 1);
        txn(16'h1000, 1'b1, 8'h77, 1'b0, 0);
        txn(16'h8010, 1'b1, 8'h3C, 1'b0, 0);
        txn(16'h8010, 1'b1, 8'hFF, 1'b1, 0);
        txn(16'h8010, 1'b0, 8'h00, 1'b0, 0);
        txn(16'hC010, 1'b1, 8'hFF, 1'b0, 0);
        ena_mode = 1'b1;
        txn(16'hC123, 1'b0, 8'h00, 1'b0, 1);
        txn(16'h8123, 1'b1, 8'h5C, 1'b0, 1);
        txn(16'h8123, 1'b0, 8'h00, 1'b0, 0);
        ena_mode = 1'b0;
        foreach (pool[j]) begin
            txn({2'b10, pool[j]}, 1'b1, 8'($urandom), 1'b0, 0);
            txn({2'b01, pool[j]}, 1'b1, 8'($urandom), 1'b0, 0);
        end

        // reset in the middle of a waited write; request still active at release
        txn(16'h8200, 1'b1, 8'h5A, 1'b0, 0);
        @(negedge clk);
        mon_on = 1'b0;
        @(posedge clk); #1;
        ibus.addr = 16'h8200; ibus.dmaster = 8'hC3;
        ibus.mreqn = 1'b0; ibus.wrn = 1'b0; ibus.rdn = 1'b1;
        ena_cycles(1);
        check("rst_pre_mwait", obus_s[0].mwait, 0);
        rstn = 1'b0;
        #1;
        check("rst_mwait_immediate", obus_s[0].mwait, 1);
        check("rst_dslave_cleared", obus_s[0].dslave, 0);
        @(posedge clk);
        #2 rstn = 1'b1;
        lows = 0;
        repeat (4) begin
            @(negedge clk);
            if (!obus_s[0].mwait) lows++;
            @(posedge clk);
        end
        check("rst_no_wait_after_release", lows, 0);
        #1;
        ibus.mreqn = 1'b1; ibus.wrn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            last_m[i] = 8'h00; known_m[i] = 1'b1;
        end
        @(posedge clk); #1;
        mon_on = 1'b1;
        txn(16'h8200, 1'b0, 8'h00, 1'b0, 0);
        txn(16'h8200, 1'b1, 8'h96, 1'b0, 1);
        txn(16'h8200, 1'b0, 8'h00, 1'b0, 0);

        // randomized traffic over all regions
        repeat (300) begin
            logic [15:0] a;
            a = {2'b00, pool[$urandom_range(7)]};
            case ($urandom_range(3))
                0:       a[15:14] = 2'b10;
                1:       a[15:14] = 2'b01;
                2:       a[15:14] = 2'b11;
                default: a[15:14] = 2'b00;
            endcase
            ena_mode = ($urandom_range(1) == 1);
            txn(a, ($urandom_range(1) == 1), 8'($urandom), ($urandom_range(3) == 0), $urandom_range(2));
        end
        ena_mode = 1'b0;
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
